// File: rtl/tinysat_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tinysat_pkg
//  Brief    : Shared types and constants for the tinysat_gen brute-force
//             k-SAT solver (FSM states, mode encoding, literal layout).
//  Revision : 1.0  initial parametrised release
// ============================================================================
package tinysat_pkg;

   // Search controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_FOUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Search mode, sampled on start
   localparam logic MODE_PAUSE = 1'b0;
   localparam logic MODE_COUNT = 1'b1;

   // Literal word is {valid, negate, var_idx}; these offsets sit directly
   // above the IDX_W-bit variable index field.
   localparam int LIT_NEG_BIT   = 0;
   localparam int LIT_VALID_BIT = 1;

   // Width of the variable index field for a given variable count
   function automatic int idx_width(input int num_vars);
      return (num_vars <= 2) ? 1 : $clog2(num_vars);
   endfunction

   // Width of a full literal word (index + negate + valid)
   function automatic int lit_width(input int num_vars);
      return idx_width(num_vars) + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tinysat_clause_eval.sv
`default_nettype none
// ============================================================================
//  Module   : tinysat_clause_eval
//  Brief    : Combinational evaluation of one LITS-literal clause against the
//             current assignment. Absent literals are skipped, out-of-range
//             variable indices read as false, an all-absent clause is true.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module tinysat_clause_eval
   import tinysat_pkg::*;
#(
   parameter int NUM_VARS = 6,
   parameter int LITS     = 3,
   parameter int IDX_W    = 3,
   parameter int LIT_W    = 5
) (
   input  logic [LITS*LIT_W-1:0] clause_i,
   input  logic [NUM_VARS-1:0]   x_i,
   output logic                  clause_true_o
);

   logic [LITS-1:0] lit_present;
   logic [LITS-1:0] lit_true;

   for (genvar l = 0; l < LITS; l++) begin : g_lit
      logic [LIT_W-1:0] word;
      logic             sel_x;
      logic             sel_hit;

      assign word = clause_i[l*LIT_W +: LIT_W];

      // Select x[var_idx]; sel_hit stays low when the index names no variable
      always_comb begin
         sel_x   = 1'b0;
         sel_hit = 1'b0;
         for (int v = 0; v < NUM_VARS; v++) begin
            if (word[IDX_W-1:0] == IDX_W'(v)) begin
               sel_x   = x_i[v];
               sel_hit = 1'b1;
            end
         end
      end

      assign lit_present[l] = word[IDX_W+LIT_VALID_BIT];
      assign lit_true[l]    = word[IDX_W+LIT_VALID_BIT] & sel_hit
                              & (sel_x ^ word[IDX_W+LIT_NEG_BIT]);
   end

   assign clause_true_o = ~(|lit_present) | (|lit_true);

endmodule
`default_nettype wire

// File: rtl/tinysat_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tinysat_gen
//  Brief    : Parametrised brute-force k-SAT solver. Clause memory is loaded
//             over a streaming port; the search walks every assignment from 0
//             upward, one clause per cycle, and either pauses at each
//             solution or counts all of them.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module tinysat_gen
   import tinysat_pkg::*;
#(
   parameter  int NUM_VARS     = 6,
   parameter  int LOG2_CLAUSES = 4,
   parameter  int LITS         = 3,
   localparam int IDX_W        = idx_width(NUM_VARS),
   localparam int LIT_W        = lit_width(NUM_VARS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_valid_i,
   input  logic [LIT_W-1:0]    load_data_i,
   output logic                load_ready_o,
   input  logic                start_i,
   input  logic                mode_i,
   input  logic                next_i,
   output logic                busy_o,
   output logic                sol_valid_o,
   output logic [NUM_VARS-1:0] sol_x_o,
   output logic                sat_o,
   output logic [NUM_VARS:0]   sol_count_o,
   output logic                done_o
);

   localparam int NUM_CLAUSES = 2 ** LOG2_CLAUSES;
   localparam int DEPTH       = NUM_CLAUSES * LITS;
   localparam int PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LOG2_CLAUSES-1:0] CIDX_LAST = {LOG2_CLAUSES{1'b1}};
   localparam logic [NUM_VARS-1:0]     X_MAX     = {NUM_VARS{1'b1}};
   localparam logic [NUM_VARS:0]       CNT_MAX   = {(NUM_VARS+1){1'b1}};

   // Flat literal store: slot ptr holds clause ptr/LITS, literal ptr%LITS
   logic [LIT_W-1:0]         mem_q [DEPTH];
   logic [PTR_W-1:0]         ptr_q;
   logic [PTR_W-1:0]         ptr_d;
   logic                     load_accept;

   state_t                   state_q;
   logic [NUM_VARS-1:0]      x_q;
   logic [LOG2_CLAUSES-1:0]  cidx_q;
   logic                     mode_q;
   logic [NUM_VARS-1:0]      sol_x_q;
   logic                     sat_q;
   logic [NUM_VARS:0]        sol_count_q;
   logic                     done_q;
   logic                     busy_q;
   logic                     sol_valid_q;
   logic                     load_ready_q;

   logic [LITS*LIT_W-1:0]    clause_words;
   logic                     clause_true;

   assign load_accept = load_valid_i & load_ready_q;

   // Load pointer advance with wrap at the last slot
   always_comb begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == PTR_W'(DEPTH - 1)) begin
         ptr_d = '0;
      end
   end

   // Load pointer register; only reset clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (load_accept) begin
         ptr_q <= ptr_d;
      end
   end

   // Clause memory write port; contents survive reset
   always_ff @(posedge clk) begin
      if (load_accept) begin
         mem_q[ptr_q] <= load_data_i;
      end
   end

   // Combinational read of all literals of clause cidx
   for (genvar l = 0; l < LITS; l++) begin : g_rd
      assign clause_words[l*LIT_W +: LIT_W] = mem_q[PTR_W'(int'(cidx_q) * LITS + l)];
   end

   tinysat_clause_eval #(
      .NUM_VARS (NUM_VARS),
      .LITS     (LITS),
      .IDX_W    (IDX_W),
      .LIT_W    (LIT_W)
   ) u_clause_eval (
      .clause_i      (clause_words),
      .x_i           (x_q),
      .clause_true_o (clause_true)
   );

   // Search controller with registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         cidx_q       <= '0;
         mode_q       <= MODE_PAUSE;
         sol_x_q      <= '0;
         sat_q        <= 1'b0;
         sol_count_q  <= '0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         sol_valid_q  <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_q      <= ST_EVAL;
                  x_q          <= '0;
                  cidx_q       <= '0;
                  sol_count_q  <= '0;
                  sat_q        <= 1'b0;
                  done_q       <= 1'b0;
                  mode_q       <= mode_i;
                  busy_q       <= 1'b1;
                  load_ready_q <= 1'b0;
               end
            end

            ST_EVAL: begin
               if (clause_true && (cidx_q != CIDX_LAST)) begin
                  cidx_q <= cidx_q + 1'b1;
               end else if (clause_true) begin
                  // Every clause held for x: record the solution
                  sol_x_q <= x_q;
                  sat_q   <= 1'b1;
                  if (sol_count_q != CNT_MAX) begin
                     sol_count_q <= sol_count_q + 1'b1;
                  end
                  if (mode_q == MODE_PAUSE) begin
                     state_q     <= ST_FOUND;
                     sol_valid_q <= 1'b1;
                  end else if (x_q == X_MAX) begin
                     state_q      <= ST_DONE;
                     done_q       <= 1'b1;
                     busy_q       <= 1'b0;
                     load_ready_q <= 1'b1;
                  end else begin
                     x_q    <= x_q + 1'b1;
                     cidx_q <= '0;
                  end
               end else if (x_q == X_MAX) begin
                  state_q      <= ST_DONE;
                  done_q       <= 1'b1;
                  busy_q       <= 1'b0;
                  load_ready_q <= 1'b1;
               end else begin
                  x_q    <= x_q + 1'b1;
                  cidx_q <= '0;
               end
            end

            ST_FOUND: begin
               if (next_i) begin
                  sol_valid_q <= 1'b0;
                  if (x_q == X_MAX) begin
                     state_q      <= ST_DONE;
                     done_q       <= 1'b1;
                     busy_q       <= 1'b0;
                     load_ready_q <= 1'b1;
                  end else begin
                     state_q <= ST_EVAL;
                     x_q     <= x_q + 1'b1;
                     cidx_q  <= '0;
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign load_ready_o = load_ready_q;
   assign busy_o       = busy_q;
   assign sol_valid_o  = sol_valid_q;
   assign sol_x_o      = sol_x_q;
   assign sat_o        = sat_q;
   assign sol_count_o  = sol_count_q;
   assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tinysat_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tinysat_gen
//  Brief    : Scoreboard bench for tinysat_gen with default parameters
//             (6 variables, 16 clauses, 3 literals, 5-bit literal words).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tinysat_gen;

   localparam int NV    = 6;
   localparam int LW    = 5;
   localparam int DEPTH = 48;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_valid;
   logic [LW-1:0] load_data;
   logic          load_ready;
   logic          start;
   logic          mode;
   logic          next;
   logic          busy;
   logic          sol_valid;
   logic [NV-1:0] sol_x;
   logic          sat;
   logic [NV:0]   sol_count;
   logic          done;

   typedef struct packed {
      logic          is_done;
      logic [NV-1:0] x;
      logic          sat;
      logic [NV:0]   cnt;
   } exp_t;

   exp_t          exp_q[$];
   logic [LW-1:0] img [DEPTH];
   int            errors = 0;
   int            checks = 0;
   int            cyc;

   tinysat_gen #(
      .NUM_VARS     (6),
      .LOG2_CLAUSES (4),
      .LITS         (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load_valid_i (load_valid),
      .load_data_i  (load_data),
      .load_ready_o (load_ready),
      .start_i      (start),
      .mode_i       (mode),
      .next_i       (next),
      .busy_o       (busy),
      .sol_valid_o  (sol_valid),
      .sol_x_o      (sol_x),
      .sat_o        (sat),
      .sol_count_o  (sol_count),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic push(input logic is_done, input logic [NV-1:0] x,
                       input logic s, input logic [NV:0] cnt);
      exp_t e;
      e.is_done = is_done;
      e.x       = x;
      e.sat     = s;
      e.cnt     = cnt;
      exp_q.push_back(e);
   endtask

   // Monitor: a rising sol_valid or done is a DUT output event
   initial begin
      logic pv;
      logic pd;
      exp_t e;
      pv = 1'b0;
      pd = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && ((sol_valid && !pv) || (done && !pd))) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("event_kind", {31'd0, done}, {31'd0, e.is_done});
               check("sol_x", {26'd0, sol_x}, {26'd0, e.x});
               check("sat", {31'd0, sat}, {31'd0, e.sat});
               check("sol_count", {25'd0, sol_count}, {25'd0, e.cnt});
            end
         end
         pv = sol_valid;
         pd = done;
      end
   end

   task automatic clear_img();
      for (int i = 0; i < DEPTH; i++) img[i] = '0;
   endtask

   task automatic load_image();
      for (int i = 0; i < DEPTH; i++) begin
         load_valid = 1'b1;
         load_data  = img[i];
         @(posedge clk); #1;
      end
      load_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic m);
      mode  = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (!done && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) check("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_found(input int budget);
      int n;
      n = 0;
      while (!sol_valid && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (!sol_valid) check("found_timeout", {31'd0, sol_valid}, 32'd1);
   endtask

   task automatic settle();
      @(posedge clk); #1;
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      start      = 1'b0;
      mode       = 1'b0;
      next       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_load_ready", {31'd0, load_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_sol_valid", {31'd0, sol_valid}, 32'd0);
      check("rst_sol_x", {26'd0, sol_x}, 32'd0);
      check("rst_sat", {31'd0, sat}, 32'd0);
      check("rst_sol_count", {25'd0, sol_count}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      settle();

      // 1: single clause x0 -> every odd assignment satisfies
      clear_img();
      img[0] = 5'h10;
      load_image();
      push(1'b1, 6'd63, 1'b1, 7'd32);
      pulse_start(1'b1);
      wait_done(3000, cyc);
      settle();

      // 2: x0 AND ~x0 -> unsatisfiable; 32 one-cycle + 32 two-cycle rejects.
      // sol_x is not cleared by start, so it keeps the previous 63.
      clear_img();
      img[0] = 5'h10;
      img[3] = 5'h18;
      load_image();
      push(1'b1, 6'd63, 1'b0, 7'd0);
      pulse_start(1'b1);
      wait_done(3000, cyc);
      check("unsat_eval_cycles", cyc, 32'd96);
      settle();

      // 3: (~x0 | x1) AND x0 -> x0=x1=1, solutions 3,7,...,63 one at a time
      clear_img();
      img[0] = 5'h18;
      img[1] = 5'h11;
      img[3] = 5'h10;
      load_image();
      for (int k = 0; k < 16; k++) push(1'b0, 6'(4*k + 3), 1'b1, 7'(k + 1));
      push(1'b1, 6'd63, 1'b1, 7'd16);
      pulse_start(1'b0);
      for (int k = 0; k < 16; k++) begin
         wait_found(3000);
         next = 1'b1;
         @(posedge clk); #1;
         next = 1'b0;
      end
      wait_done(3000, cyc);
      settle();

      // 4: same clauses counted; start pulses while busy are ignored
      push(1'b1, 6'd63, 1'b1, 7'd16);
      pulse_start(1'b1);
      repeat (5) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         @(posedge clk); #1;
      end
      wait_done(3000, cyc);
      settle();

      // 5: reset mid-search, then restart on the retained clause memory
      pulse_start(1'b1);
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_sol_count", {25'd0, sol_count}, 32'd0);
      check("midrst_load_ready", {31'd0, load_ready}, 32'd1);
      check("midrst_sat", {31'd0, sat}, 32'd0);
      reset = 1'b0;
      settle();
      push(1'b1, 6'd63, 1'b1, 7'd16);
      pulse_start(1'b1);
      wait_done(3000, cyc);
      settle();

      // 6a: words offered during the search are dropped
      push(1'b1, 6'd63, 1'b1, 7'd16);
      pulse_start(1'b1);
      load_valid = 1'b1;
      load_data  = 5'h18;
      wait_done(3000, cyc);
      load_valid = 1'b0;
      settle();

      // 6b: 48 words wrap the pointer; word 49 replaces slot 0 with ~x0
      clear_img();
      img[0] = 5'h10;
      load_image();
      load_valid = 1'b1;
      load_data  = 5'h18;
      @(posedge clk); #1;
      load_valid = 1'b0;
      push(1'b1, 6'd62, 1'b1, 7'd32);
      pulse_start(1'b1);
      wait_done(3000, cyc);
      settle();
      settle();

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tinysat_gen.md
Name: tinysat_gen

Overview:
Parametrised brute-force k-SAT solver, the successor to the team's fixed 4-variable, 2-literal solver. It holds a clause memory loaded over a streaming interface. It enumerates every variable assignment from 0 upward and evaluates one clause per cycle, moving to the next assignment as soon as any clause fails. It supports two modes: find-and-pause, which allows enumeration of successive solutions, and full solution counting.

Parameters:
NUM_VARS, 6, number of boolean variables; assignment counter width (2..16).
LOG2_CLAUSES, 4, log2 of clause slots; NUM_CLAUSES = 2**LOG2_CLAUSES.
LITS, 3, literals per clause (1..4).
IDX_W, $clog2(NUM_VARS), derived variable-index width; not overridable.
LIT_W, IDX_W+2, derived literal word width; not overridable.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
load_valid  in  1  literal word present on load_data
load_data  in  LIT_W  literal {valid, negate, var_idx[IDX_W-1:0]}
load_ready  out  1  load accepted this cycle (=1 only in IDLE/DONE)
start  in  1  single-cycle pulse: begin search
mode  in  1  0 = pause at each solution, 1 = count all; sampled at start
next  in  1  pulse: resume search from FOUND (mode 0)
busy  out  1  state is EVAL or FOUND
sol_valid  out  1  high throughout FOUND
sol_x  out  NUM_VARS  last satisfying assignment (bit i = var i)
sat  out  1  at least one solution found since start
sol_count  out  NUM_VARS+1  solutions found since start, saturating
done  out  1  search exhausted; held until next start

Behaviour:
- Reset values:
  - state=IDLE; load_ready=1; busy=0; sol_valid=0; sol_x=0; sat=0; sol_count=0; done=0.
  - Load pointer and assignment/clause counters are cleared to 0.
  - Clause memory is NOT reset.
  - Reset has priority in every state, including mid-search.
- Literal semantics:
  - valid=0 means the literal is absent.
  - A present literal evaluates to x[var_idx] XOR negate.
  - A var_idx >= NUM_VARS evaluates false.
  - A clause is the OR of its present literals. A clause with no present literals evaluates TRUE (empty slot).
- Load:
  - Each accepted word (load_valid & load_ready) writes to slot ptr.
  - ptr: clause = ptr/LITS, literal = ptr%LITS; ptr increments by 1.
  - ptr wraps from NUM_CLAUSES*LITS-1 to 0.
  - ptr is cleared by reset only.
  - Words offered while load_ready=0 are dropped.
- FSM states: IDLE, EVAL, FOUND, DONE.
  - IDLE/DONE + start -> EVAL. On this transition: x=0, cidx=0, sol_count=0, sat=0, done=0, mode latched.
  - EVAL (one clause per cycle, combinational read of clause cidx):
    - Clause true and cidx<last: cidx+1.
    - Clause true and cidx==last: solution. Then sol_x<=x, sat<=1, sol_count+1 (saturating at all-ones).
      - mode0 -> FOUND.
      - mode1 and x==max -> DONE.
      - mode1 otherwise -> x+1, cidx=0.
    - Clause false: x==max -> DONE; else x+1, cidx=0.
  - FOUND: sol_valid=1; x is held. next with x<max -> EVAL at x+1, cidx=0. next with x==max -> DONE.
  - DONE: done=1. sol_x, sat and sol_count are held.
- Ignored inputs: start while busy; next outside FOUND.
- Timing:
  - done rises the cycle after the final EVAL cycle.
  - Worst-case search length is 2**NUM_VARS * NUM_CLAUSES EVAL cycles.

Decomposition:
- Package tinysat_pkg: state enum; mode constants (MODE_PAUSE=0, MODE_COUNT=1); literal field offsets (LIT_VALID_BIT, LIT_NEG_BIT); LIT_W/IDX_W helper function.
- Sub-module tinysat_clause_eval: combinational LITS-literal evaluator (clause words, x -> clause_true). One instance.

Test Plan:
1. Defaults, load slot0 = {0x10,0x00,0x00} (x0), all other slots empty, mode=1, start -> done; sat=1; sol_count=32; sol_x=63.
2. Clause0 = x0 (0x10), clause1 = ~x0 (0x18), rest empty, mode=1, start -> done exactly 96 EVAL cycles after start; sat=0; sol_count=0.
3. Clause0 = {~x0 (0x18), x1 (0x11)}, clause1 = x0 (0x10), mode=0, start -> FOUND with sol_x=3. next -> sol_x=7, then 11. After 16 solutions, next -> done=1.
4. Same clauses, mode=1 -> sol_count=16, sol_x=63; start pulses during busy are ignored and the count is unchanged.
5. Reset asserted mid-EVAL -> next cycle busy=0, done=0, sol_count=0, load_ready=1. Restart without reload -> same result as before the reset.
6. load_valid held during search -> no memory change. Loading 48 words wraps ptr; a 49th word overwrites slot 0.
